// File: rtl/demux_n_1_4.sv
// demux_n_1_4: 1-to-4 valid/ready stream demultiplexer.
// Each output has its own 2-entry FIFO. A stalled output only blocks words
// addressed to it. in_ready depends only on sel and the registered counts, so
// there is no combinational path from out_ready to in_ready.
module demux_n_1_4 #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_0,
  input  logic [1:0]   sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_y_0,
  output logic [N-1:0] out_y_1,
  output logic [N-1:0] out_y_2,
  output logic [N-1:0] out_y_3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready
);

  // Per-channel storage, 1-bit pointers and occupancy (0..2).
  logic [3:0][1:0][N-1:0] mem_q, mem_d;
  logic [3:0]             rd_ptr_q, rd_ptr_d;
  logic [3:0]             wr_ptr_q, wr_ptr_d;
  logic [3:0][1:0]        cnt_q, cnt_d;

  logic [3:0] push;
  logic [3:0] pop;

  // Handshake decode: accept unless the addressed FIFO is full.
  always_comb begin
    in_ready = (cnt_q[sel] != 2'd2);
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (cnt_q[k] != 2'd0);
      push[k]      = in_valid && in_ready && (sel == 2'(k));
      pop[k]       = out_valid[k] && out_ready[k];
    end
  end

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = in_0;
        wr_ptr_d[k]           = ~wr_ptr_q[k];
      end
      if (pop[k]) begin
        rd_ptr_d[k] = ~rd_ptr_q[k];
      end
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // State register; synchronous reset also clears storage so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Head-of-FIFO outputs, straight from registered storage.
  always_comb begin
    out_y_0 = mem_q[0][rd_ptr_q[0]];
    out_y_1 = mem_q[1][rd_ptr_q[1]];
    out_y_2 = mem_q[2][rd_ptr_q[2]];
    out_y_3 = mem_q[3][rd_ptr_q[3]];
  end

endmodule

// File: tb/tb_demux_n_1_4.sv
// Testbench for demux_n_1_4: stimulus pushes accepted words into per-channel
// expectation queues; a negedge monitor pops and compares on each output transfer.
module tb_demux_n_1_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_0;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_y_0, out_y_1, out_y_2, out_y_3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  demux_n_1_4 #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_0      (in_0),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_y_0   (out_y_0),
    .out_y_1   (out_y_1),
    .out_y_2   (out_y_2),
    .out_y_3   (out_y_3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: each queue holds exactly the words channel k should contain.
  logic [7:0] exp_q [4][$];
  bit         exp_ready;
  bit         acc;
  bit         mon_en = 1'b0;
  int         vectors = 0;
  int         errors  = 0;
  int         ch3_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] y_of(input int k);
    case (k)
      0:       return out_y_0;
      1:       return out_y_1;
      2:       return out_y_2;
      default: return out_y_3;
    endcase
  endfunction

  // Monitor: readiness from model occupancy (before this cycle's pops), then
  // compare every presented head and retire words the consumer takes.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = (exp_q[sel].size() != 2);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
              {31'd0, exp_q[k].size() != 0});
        if (out_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("spurious_out%0d", k), {24'd0, y_of(k)}, 32'hFFFF_FFFF);
          end else begin
            check($sformatf("out_y_%0d", k), {24'd0, y_of(k)}, {24'd0, exp_q[k][0]});
            if (out_ready[k] && !rst) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // One clock: record the transfer the model says happens at this edge.
  task automatic step();
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else if (in_valid && exp_ready) begin
      exp_q[sel].push_back(in_0);
      acc = 1'b1;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_0     = d;
    sel      = s;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_0 = 8'hEE; sel = 2'd1; out_ready = 4'hF;
    // Reset with in_valid high: nothing may be captured.
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_y", {out_y_0, out_y_1, out_y_2, out_y_3}, 32'd0);
    mon_en = 1'b1;

    // Routing, back to back.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_0 = 8'hA0 + 8'(k);
      sel  = 2'(k);
      step();
      check("route_acc", {31'd0, acc}, 32'd1);
    end
    idle(3);

    // Backpressure on channel 2.
    out_ready = 4'b1011;
    send(8'h10, 2'd2);
    send(8'h11, 2'd2);
    in_valid = 1'b1; in_0 = 8'h12; sel = 2'd2;
    step(); step(); step();
    check("bp_stall", {31'd0, acc}, 32'd0);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_head", {24'd0, out_y_2}, 32'h10);
    out_ready = 4'hF;
    step();
    check("bp_full_pop_noacc", {31'd0, acc}, 32'd0);
    check("bp_ready_recover", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_third_acc", {31'd0, acc}, 32'd1);
    idle(4);

    // Isolation: channel 1 stalled, alternate sel 1 / sel 3; abandon blocked words.
    out_ready = 4'b1101;
    ch3_acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_0 = 8'h20 + 8'(i); sel = (i % 2 == 0) ? 2'd1 : 2'd3;
      for (int t = 0; t < 3; t++) begin
        step();
        if (acc) break;
      end
      if (acc && sel == 2'd3) ch3_acc++;
      if (!acc) idle(1);
    end
    check("iso_ch3_all", ch3_acc, 32'd4);
    out_ready = 4'hF;
    idle(4);

    // Streaming push+pop into channel 0 at count 1.
    in_valid = 1'b1; sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in_0 = 8'h30 + 8'(i);
      step();
      check("stream_acc", {31'd0, acc}, 32'd1);
    end
    idle(3);
    check("stream_drained", exp_q[0].size(), 32'd0);

    // Mid-operation reset with channels 0 and 3 full.
    out_ready = 4'h0;
    send(8'h40, 2'd0); send(8'h41, 2'd3); send(8'h42, 2'd0); send(8'h43, 2'd3);
    check("mid_full", {28'd0, out_valid}, 32'h9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {28'd0, out_valid}, 32'd0);
    check("mid_rst_y3", {24'd0, out_y_3}, 32'd0);
    send(8'h55, 2'd3);
    check("mid_55_head", {24'd0, out_y_3}, 32'h55);
    out_ready = 4'hF;
    idle(3);

    // Randomized traffic obeying the hold rule.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !acc)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_0     = 8'($urandom);
        sel      = 2'($urandom);
      end
      out_ready = 4'($urandom);
      step();
    end
    out_ready = 4'hF;
    idle(5);
    for (int k = 0; k < 4; k++) check($sformatf("final_drain%0d", k), exp_q[k].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
